cpc_rom_ctrl: RTL and testbench
===============================

# cpc_rom_ctrl

Single-CPLD controller for the eight-slot upper-ROM board. It sits between the CPC expansion edge connector and four paired 32K EEPROMs. It captures the ROM-select I/O write, decodes the selected slot against the board's bank and slot mask, and drives the chip selects, ROM A14 and ROMDIS. It also sequences in-system EEPROM writes behind a two-key unlock, a write-cycle busy timer and a status port.

## Interface
- BANK, 1'b0: slot group served; 0 = ROMs 0–7, 1 = ROMs 8–15.
- SLOT_MASK, 8'hFF: bit n = 1 means slot n is populated and may be decoded.
- WP_MASK, 8'h00: bit n = 1 means slot n is write-protected regardless of unlock.
- CTRL_PORT, 8'hF8: A15:A8 match for the control/status port. A13 must be 1, so it never aliases the ROM-select port.
- BUSY_CYCLES, 40000: EEPROM tWC in CLK cycles (10 ms at 4 MHz); counter width is clog2(BUSY_CYCLES+1).

Ports:
- CLK  in  1  CPC 4 MHz clock; all state updates on rising edge.
- RESET_B  in  1  async active-low reset; one clock, async assert, async active-low fixed.
- A  in  16  Z80 address bus.
- D  in  8  Z80 data bus, input side.
- IOREQ_B, MREQ_B, RD_B, WR_B, ROMEN_B  in  1 each  Z80/gate-array strobes, active low.
- d_out  out  8  status byte.
- d_oe  out  1  drive d_out onto D.
- cs_b  out  4  per-pair EEPROM chip select, active low; pair = slot[2:1].
- rom_a14  out  1  EEPROM A14 = romsel[0].
- rom_we_b  out  1  EEPROM write enable, active low.
- romdis  out  1  to the ROMDIS diode; high disables internal ROM.
- busy  out  1  write cycle in progress.

## Operation
- **Strobes.** IOREQ_B, MREQ_B, RD_B and WR_B are registered once and edge-detected on the falling edge of the combined strobe. Each bus cycle yields exactly one event.
- **ROM select.** An I/O write with A13=0 loads `romsel <= D` on the event cycle.
- **Slot decode.**
  - valid = (romsel[7:4]==0) & (romsel[3]==BANK) & SLOT_MASK[romsel[2:0]].
  - cs_b[romsel[2:1]] low iff valid & A[14] & !busy; all other cs_b bits high.
  - romdis = valid & !busy.
- **Control port.** An I/O write with A[15:8]==CTRL_PORT drives the unlock FSM:
  - LOCKED: D=8'hA5 → KEY1; any other value → LOCKED.
  - KEY1: D=8'h5A → ARMED; any other value → LOCKED.
  - ARMED: any control write → LOCKED. A memory write with A[15:14]==2'b11 to a valid, non-WP slot, with busy=0, → WRITE.
  - WRITE: rom_we_b low for exactly one CLK cycle, then → BUSY and load the timer.
  - BUSY: timer counts down; reaching 0 → ARMED. All memory writes and unlock attempts are ignored; control writes of any value → LOCKED once BUSY ends. This "lock pending" is a sticky flag.
- **Memory writes while not armed.** Writes to the ROM window in LOCKED or KEY1 are ignored; the FSM does not change.
- **Status read.** While IOREQ_B=0, RD_B=0 and A[15:8]==CTRL_PORT, d_oe=1 combinationally. d_out = {busy, armed, key1, lock_pending, valid, romsel[2:0]}.
- **Simultaneous events.** An I/O and a memory event cannot coincide on the Z80 bus. If both decode in one cycle, the I/O event wins and the memory event is dropped.

## Timing
- **Reset values.** romsel=0, FSM LOCKED, timer 0, lock_pending 0, cs_b=4'hF, rom_we_b=1, romdis=0, busy=0, d_oe=0, d_out=0.
- **Reset mid-write.** Asserting RESET_B mid-WRITE or mid-BUSY returns rom_we_b high immediately and clears busy.
- **Strobe to event.** 2 CLK cycles: sync, then edge.
- **romsel.** Visible on cs_b/romdis on the cycle after the event.
- **rom_we_b.** Low for the cycle following the write event and high again before WR_B rises. D is held by the CPU across that cycle.
- **busy.** High from the cycle after the WE pulse for exactly BUSY_CYCLES cycles.
- **Timer boundary.** The timer never wraps; a zero load (BUSY_CYCLES=0) passes straight to ARMED.

## Structure
- Package cpc_rom_ctrl_pkg holds:
  - FSM state enum (LOCKED, KEY1, ARMED, WRITE, BUSY);
  - KEY1_VAL 8'hA5, KEY2_VAL 8'h5A;
  - status bit index constants.
- Sub-module cpc_rom_wtimer: loadable down-counter with a done pulse, parameterised by BUSY_CYCLES.

## Test plan
- **Select and decode.** Reset, then OUT &DF00,5 with BANK=0 → cs_b=4'b1011, rom_a14=1 and romdis=1 while A14=1; OUT 12 → romdis=0, cs_b=4'hF.
- **Slot mask.** SLOT_MASK=8'hFE, select 0 → romdis=0, cs_b=4'hF.
- **Unlock and write.** OUT &F8xx,&A5, OUT &5A, then write to &C123 with slot 2 selected → one-cycle rom_we_b pulse; busy high for BUSY_CYCLES (set 16 in sim); cs_b high throughout; status returns ARMED afterwards.
- **Bad key and protection.** &A5 then &11 → LOCKED and the next write gives no WE. WP_MASK bit set while ARMED → no WE, FSM stays ARMED.
- **Write during BUSY.** Second write during BUSY → ignored. A control write during BUSY → LOCKED after the timer expires; status bit 4 is set meanwhile.
- **Reset mid-BUSY.** Assert reset at the timer midpoint → busy=0, FSM LOCKED, romsel=0 immediately.

Source files
------------

// File: rtl/cpc_rom_ctrl_pkg.sv
// Shared types and constants for the CPC upper-ROM board controller.
// Holds the unlock/write FSM encoding, unlock keys and status-byte layout.
package cpc_rom_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_KEY1,
        ST_ARMED,
        ST_WRITE,
        ST_BUSY
    } rom_state_e;

    localparam logic [7:0] KEY1_VAL = 8'hA5;
    localparam logic [7:0] KEY2_VAL = 8'h5A;

    localparam int STAT_BUSY      = 7;
    localparam int STAT_ARMED     = 6;
    localparam int STAT_KEY1      = 5;
    localparam int STAT_LOCK_PEND = 4;
    localparam int STAT_VALID     = 3;

    // A zero-cycle timer still needs a one-bit counter to exist.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cpc_rom_wtimer.sv
// EEPROM write-cycle timer: loadable down-counter that stops at zero and
// pulses done_o on the last counting cycle.
module cpc_rom_wtimer
    import cpc_rom_ctrl_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 40000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic done_o
);

    localparam int unsigned CNT_W = cnt_width(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BUSY_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1)) && !load_i;

endmodule

// File: rtl/cpc_rom_ctrl.sv
// CPLD controller for the eight-slot upper-ROM board: ROM-select capture,
// slot decode, chip selects/ROMDIS and the unlocked EEPROM write sequencer.
module cpc_rom_ctrl
    import cpc_rom_ctrl_pkg::*;
#(
    parameter logic        BANK        = 1'b0,
    parameter logic [7:0]  SLOT_MASK   = 8'hFF,
    parameter logic [7:0]  WP_MASK     = 8'h00,
    parameter logic [7:0]  CTRL_PORT   = 8'hF8,
    parameter int unsigned BUSY_CYCLES = 40000
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        IOREQ_B,
    input  logic        MREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        ROMEN_B,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic [3:0]  cs_b,
    output logic        rom_a14,
    output logic        rom_we_b,
    output logic        romdis,
    output logic        busy
);

    logic iorq_q, mreq_q, wr_q;
    logic io_wr_prev_q, mem_wr_prev_q;
    logic io_wr, mem_wr, io_evt, mem_evt;
    logic sel_wr, ctrl_wr, rom_wr;

    logic [7:0] romsel_q;
    logic       sel_vld_q;
    logic       valid, wp;

    rom_state_e state_q, state_d;
    logic       lock_pend_q, lock_pend_d;
    logic       timer_load, timer_done;
    logic [7:0] status;
    logic       unused_ok;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            iorq_q        <= 1'b1;
            mreq_q        <= 1'b1;
            wr_q          <= 1'b1;
            io_wr_prev_q  <= 1'b0;
            mem_wr_prev_q <= 1'b0;
        end else begin
            iorq_q        <= IOREQ_B;
            mreq_q        <= MREQ_B;
            wr_q          <= WR_B;
            io_wr_prev_q  <= io_wr;
            mem_wr_prev_q <= mem_wr;
        end
    end

    assign io_wr   = !iorq_q && !wr_q;
    assign mem_wr  = !mreq_q && !wr_q;
    assign io_evt  = io_wr && !io_wr_prev_q;
    // An I/O event always wins over a memory event decoded in the same cycle.
    assign mem_evt = mem_wr && !mem_wr_prev_q && !io_evt;

    assign sel_wr  = io_evt && !A[13];
    assign ctrl_wr = io_evt && (A[15:8] == CTRL_PORT);
    assign rom_wr  = mem_evt && (A[15:14] == 2'b11);

    // sel_vld_q keeps slot 0 from being decoded out of reset before any select.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            romsel_q  <= 8'h00;
            sel_vld_q <= 1'b0;
        end else if (sel_wr) begin
            romsel_q  <= D;
            sel_vld_q <= 1'b1;
        end
    end

    assign valid = sel_vld_q && (romsel_q[7:4] == 4'h0) && (romsel_q[3] == BANK)
                && SLOT_MASK[romsel_q[2:0]];
    assign wp    = WP_MASK[romsel_q[2:0]];

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        lock_pend_d = lock_pend_q;
        timer_load  = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                if (ctrl_wr) state_d = (D == KEY1_VAL) ? ST_KEY1 : ST_LOCKED;
            end
            ST_KEY1: begin
                if (ctrl_wr) state_d = (D == KEY2_VAL) ? ST_ARMED : ST_LOCKED;
            end
            ST_ARMED: begin
                if (ctrl_wr) begin
                    state_d = ST_LOCKED;
                end else if (rom_wr && valid && !wp) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                timer_load = 1'b1;
                if (ctrl_wr) lock_pend_d = 1'b1;
                if (BUSY_CYCLES == 0) begin
                    state_d     = lock_pend_d ? ST_LOCKED : ST_ARMED;
                    lock_pend_d = 1'b0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ctrl_wr) lock_pend_d = 1'b1;
                if (timer_done) begin
                    state_d     = lock_pend_d ? ST_LOCKED : ST_ARMED;
                    lock_pend_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_LOCKED;
                lock_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q     <= ST_LOCKED;
            lock_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_pend_q <= lock_pend_d;
        end
    end

    cpc_rom_wtimer #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_wtimer (
        .clk    (CLK),
        .rst_n  (RESET_B),
        .load_i (timer_load),
        .done_o (timer_done)
    );

    assign busy     = (state_q == ST_BUSY);
    assign rom_we_b = (state_q != ST_WRITE);
    assign romdis   = valid && !busy;
    assign rom_a14  = romsel_q[0];

    always_comb begin
        cs_b = 4'hF;
        if (valid && A[14] && !busy) cs_b[romsel_q[2:1]] = 1'b0;
    end

    always_comb begin
        status                 = 8'h00;
        status[STAT_BUSY]      = busy;
        status[STAT_ARMED]     = (state_q == ST_ARMED);
        status[STAT_KEY1]      = (state_q == ST_KEY1);
        status[STAT_LOCK_PEND] = lock_pend_q;
        status[STAT_VALID]     = valid;
        status[2:0]            = romsel_q[2:0];
    end

    assign d_oe  = !IOREQ_B && !RD_B && (A[15:8] == CTRL_PORT);
    assign d_out = d_oe ? status : 8'h00;

    assign unused_ok = ^{A[7:0], ROMEN_B};

endmodule

// File: tb/tb_cpc_rom_ctrl.sv
// Directed bench for cpc_rom_ctrl: select/decode, unlock, write pulse,
// busy timing, protection, lock-pending and reset during a write cycle.
module tb_cpc_rom_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        iorq_b, mreq_b, rd_b, wr_b, romen_b;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [3:0]  cs_b;
    logic        rom_a14, rom_we_b, romdis, busy;

    int n_checks = 0;
    int n_pass   = 0;

    cpc_rom_ctrl #(
        .BANK        (1'b0),
        .SLOT_MASK   (8'hFE),
        .WP_MASK     (8'h08),
        .CTRL_PORT   (8'hF8),
        .BUSY_CYCLES (16)
    ) dut (
        .CLK      (clk),
        .RESET_B  (rst_n),
        .A        (addr),
        .D        (data),
        .IOREQ_B  (iorq_b),
        .MREQ_B   (mreq_b),
        .RD_B     (rd_b),
        .WR_B     (wr_b),
        .ROMEN_B  (romen_b),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .cs_b     (cs_b),
        .rom_a14  (rom_a14),
        .rom_we_b (rom_we_b),
        .romdis   (romdis),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; data = d; iorq_b = 1'b0; wr_b = 1'b0;
        repeat (3) @(negedge clk);
        iorq_b = 1'b1; wr_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d,
                             output int we_cnt, output int busy_cnt, output int cs_bad);
        we_cnt = 0; busy_cnt = 0; cs_bad = 0;
        @(negedge clk);
        addr = a; data = d; mreq_b = 1'b0; wr_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) begin
                mreq_b = 1'b1; wr_b = 1'b1;
            end
            if (!rom_we_b) we_cnt++;
            if (busy) begin
                busy_cnt++;
                if (cs_b != 4'hF) cs_bad++;
            end
        end
    endtask

    task automatic count_busy(inout int busy_cnt, inout int cs_bad);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (cs_b != 4'hF) cs_bad++;
        end
    endtask

    task automatic chk_status(input string tag, input logic [7:0] exp);
        logic [7:0] s;
        logic       oe;
        @(negedge clk);
        addr = 16'hF800; iorq_b = 1'b0; rd_b = 1'b0;
        #1;
        s = d_out; oe = d_oe;
        @(negedge clk);
        iorq_b = 1'b1; rd_b = 1'b1;
        check(tag, s, exp);
        check({tag, "_oe"}, oe, 1'b1);
    endtask

    initial begin
        int we, bc, cb;
        rst_n = 1'b0; addr = 16'h0000; data = 8'h00;
        iorq_b = 1'b1; mreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; romen_b = 1'b1;
        #3;
        check("rst_cs_b", cs_b, 4'hF);
        check("rst_we_b", rom_we_b, 1'b1);
        check("rst_romdis", romdis, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_d_oe", d_oe, 1'b0);
        check("rst_d_out", d_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Select slot 5 and decode with A14 high, then low.
        io_write(16'hDF00, 8'h05);
        addr = 16'hC000; #1;
        check("sel5_cs_b", cs_b, 4'b1011);
        check("sel5_a14", rom_a14, 1'b1);
        check("sel5_romdis", romdis, 1'b1);
        addr = 16'h0000; #1;
        check("sel5_lo_cs_b", cs_b, 4'hF);

        // Other bank, high nibble set, unpopulated slot 0.
        io_write(16'hDF00, 8'h0C);
        addr = 16'hC000; #1;
        check("sel12_romdis", romdis, 1'b0);
        check("sel12_cs_b", cs_b, 4'hF);
        io_write(16'hDF00, 8'h15);
        addr = 16'hC000; #1;
        check("sel15h_romdis", romdis, 1'b0);
        io_write(16'hDF00, 8'h00);
        addr = 16'hC000; #1;
        check("sel0_romdis", romdis, 1'b0);
        check("sel0_cs_b", cs_b, 4'hF);

        // Slot 2, locked: write ignored.
        io_write(16'hDF00, 8'h02);
        chk_status("st_locked", 8'h0A);
        mem_write(16'hC123, 8'h33, we, bc, cb);
        check("locked_we", we, 0);

        // First key, write in KEY1 ignored and FSM stays in KEY1.
        io_write(16'hF800, 8'hA5);
        chk_status("st_key1", 8'h2A);
        mem_write(16'hC123, 8'h33, we, bc, cb);
        check("key1_we", we, 0);
        io_write(16'hF800, 8'h5A);
        chk_status("st_armed", 8'h4A);

        // Armed write: one WE cycle, 16 busy cycles with chip selects off.
        mem_write(16'hC123, 8'h44, we, bc, cb);
        check("wr_we_cnt", we, 1);
        count_busy(bc, cb);
        check("wr_busy_len", bc, 16);
        check("wr_cs_busy", cb, 0);
        chk_status("st_after_wr", 8'h4A);

        // Relock, then a bad second key.
        io_write(16'hF800, 8'h00);
        chk_status("st_relock", 8'h0A);
        io_write(16'hF800, 8'hA5);
        io_write(16'hF800, 8'h11);
        chk_status("st_badkey", 8'h0A);
        mem_write(16'hC123, 8'h55, we, bc, cb);
        check("badkey_we", we, 0);

        // Write-protected slot 3 while armed.
        io_write(16'hDF00, 8'h03);
        io_write(16'hF800, 8'hA5);
        io_write(16'hF800, 8'h5A);
        chk_status("st_wp_armed", 8'h4B);
        mem_write(16'hC123, 8'h66, we, bc, cb);
        check("wp_we", we, 0);
        chk_status("st_wp_after", 8'h4B);

        // Second write and a control write during busy.
        io_write(16'hDF00, 8'h02);
        chk_status("st_armed2", 8'h4A);
        mem_write(16'hC123, 8'h77, we, bc, cb);
        check("b2_first_we", we, 1);
        mem_write(16'hC124, 8'h78, we, bc, cb);
        check("b2_second_we", we, 0);
        io_write(16'hF800, 8'h77);
        chk_status("st_lock_pend", 8'h9A);
        bc = 0; cb = 0;
        count_busy(bc, cb);
        check("b2_busy_end", busy, 1'b0);
        chk_status("st_locked_after", 8'h0A);
        mem_write(16'hC123, 8'h79, we, bc, cb);
        check("b2_locked_we", we, 0);

        // Reset in the middle of the busy period.
        io_write(16'hF800, 8'hA5);
        io_write(16'hF800, 8'h5A);
        mem_write(16'hC123, 8'h7A, we, bc, cb);
        check("rb_we", we, 1);
        repeat (5) @(negedge clk);
        check("rb_busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_busy", busy, 1'b0);
        check("rb_we_b", rom_we_b, 1'b1);
        check("rb_romdis", romdis, 1'b0);
        check("rb_cs_b", cs_b, 4'hF);
        chk_status("rb_status", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        addr = 16'hC000; #1;
        check("rb_cs_after", cs_b, 4'hF);
        chk_status("rb_status_after", 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
